// File: rtl/sram_array_ctrl.sv
// sram_array_ctrl: sequences precharge, wordline, bitline-drive and sense
// phases for a ROWS x COLS split-port SRAM array from a valid/ready request.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake (ready only when idle)
//   req_we/req_addr/req_wdata   request fields, captured at acceptance
//   row_wr/row_rd               one-hot write/read wordlines
//   bl_wr/blb_wr                write bitline drive, true/complement
//   precharge/sense_en          read bitline precharge, sense-amp enable
//   sa_out                      sense-amp outputs, sampled at end of SENSE
//   rd_valid/rd_data            read strobe and held read data
//   addr_err                    row address out of range, flagged in REC
module sram_array_ctrl #(
    parameter int unsigned ROWS    = 4,
    parameter int unsigned COLS    = 8,
    parameter int unsigned ADDR_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int unsigned PRE_CYC = 2,
    parameter int unsigned WL_CYC  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [COLS-1:0]   req_wdata,
    output logic [ROWS-1:0]   row_wr,
    output logic [ROWS-1:0]   row_rd,
    output logic [COLS-1:0]   bl_wr,
    output logic [COLS-1:0]   blb_wr,
    output logic              precharge,
    output logic              sense_en,
    input  logic [COLS-1:0]   sa_out,
    output logic              rd_valid,
    output logic [COLS-1:0]   rd_data,
    output logic              addr_err
);

    localparam int unsigned MAX_CYC = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [ADDR_W:0] ROWS_L = (ADDR_W + 1)'(ROWS);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PRE, S_WL, S_SENSE, S_REC
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic [COLS-1:0]    wdata_q, wdata_n;
    logic               accept_c;

    logic [ROWS-1:0]    row_wr_d, row_rd_d;
    logic [COLS-1:0]    bl_wr_d, blb_wr_d, rd_data_d;
    logic               req_ready_d, precharge_d, sense_en_d, rd_valid_d, addr_err_d;

    assign accept_c = req_valid && (state_q == S_IDLE);

    // Request fields as seen by the operation starting or continuing next cycle
    assign we_n    = accept_c ? req_we    : we_q;
    assign addr_n  = accept_c ? req_addr  : addr_q;
    assign wdata_n = accept_c ? req_wdata : wdata_q;

    // State register and phase counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and phase counter; counter reloads on every state change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = req_we ? S_SETUP : S_PRE;
            S_SETUP: state_d = S_WL;
            S_PRE:   if (cnt_q == '0) state_d = S_WL;
            S_WL:    if (cnt_q == '0) state_d = we_q ? S_REC : S_SENSE;
            S_SENSE: state_d = S_REC;
            S_REC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) begin
            case (state_d)
                S_PRE:   cnt_d = CNT_W'(PRE_CYC - 1);
                S_WL:    cnt_d = CNT_W'(WL_CYC - 1);
                default: cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Request capture at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept_c) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Output decode from next state so registered outputs align with state_q
    always_comb begin
        logic            in_range;
        logic [ROWS-1:0] onehot;
        logic            drive;
        in_range    = ({1'b0, addr_n} < ROWS_L);
        onehot      = in_range ? (ROWS'(1) << addr_n) : '0;
        drive       = we_n && (state_d inside {S_SETUP, S_WL, S_REC});
        req_ready_d = (state_d == S_IDLE);
        row_wr_d    = (we_n && state_d == S_WL) ? onehot : '0;
        row_rd_d    = (!we_n && (state_d inside {S_WL, S_SENSE})) ? onehot : '0;
        bl_wr_d     = drive ? wdata_n  : '0;
        blb_wr_d    = drive ? ~wdata_n : '0;
        precharge_d = (state_d == S_PRE);
        sense_en_d  = (state_d == S_SENSE);
        rd_valid_d  = (state_d == S_REC) && !we_n;
        addr_err_d  = (state_d == S_REC) && !in_range;
        rd_data_d   = rd_data;
        // Out-of-range reads never raise a wordline, so return zero instead of sa_out
        if (state_q == S_SENSE) rd_data_d = in_range ? sa_out : '0;
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            row_wr    <= '0;
            row_rd    <= '0;
            bl_wr     <= '0;
            blb_wr    <= '0;
            precharge <= 1'b0;
            sense_en  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            addr_err  <= 1'b0;
        end else begin
            req_ready <= req_ready_d;
            row_wr    <= row_wr_d;
            row_rd    <= row_rd_d;
            bl_wr     <= bl_wr_d;
            blb_wr    <= blb_wr_d;
            precharge <= precharge_d;
            sense_en  <= sense_en_d;
            rd_valid  <= rd_valid_d;
            rd_data   <= rd_data_d;
            addr_err  <= addr_err_d;
        end
    end

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Testbench for sram_array_ctrl: two instances (default parameters, and
// ROWS=3/COLS=16/PRE_CYC=1/WL_CYC=1) driven through a shared request port,
// with a behavioural cell array feeding sa_out and a per-cycle phase model.
module tb_sram_array_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic        sel;
    logic        req_valid, req_we;
    logic [1:0]  req_addr;
    logic [15:0] req_wdata;

    logic       a_req_ready, a_precharge, a_sense_en, a_rd_valid, a_addr_err;
    logic [3:0] a_row_wr, a_row_rd;
    logic [7:0] a_bl_wr, a_blb_wr, a_sa_out, a_rd_data;

    logic        b_req_ready, b_precharge, b_sense_en, b_rd_valid, b_addr_err;
    logic [2:0]  b_row_wr, b_row_rd;
    logic [15:0] b_bl_wr, b_blb_wr, b_sa_out, b_rd_data;

    sram_array_ctrl #(.ROWS(4), .COLS(8), .PRE_CYC(2), .WL_CYC(3)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && !sel), .req_ready(a_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata[7:0]),
        .row_wr(a_row_wr), .row_rd(a_row_rd), .bl_wr(a_bl_wr), .blb_wr(a_blb_wr),
        .precharge(a_precharge), .sense_en(a_sense_en), .sa_out(a_sa_out),
        .rd_valid(a_rd_valid), .rd_data(a_rd_data), .addr_err(a_addr_err)
    );

    sram_array_ctrl #(.ROWS(3), .COLS(16), .PRE_CYC(1), .WL_CYC(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && sel), .req_ready(b_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .row_wr(b_row_wr), .row_rd(b_row_rd), .bl_wr(b_bl_wr), .blb_wr(b_blb_wr),
        .precharge(b_precharge), .sense_en(b_sense_en), .sa_out(b_sa_out),
        .rd_valid(b_rd_valid), .rd_data(b_rd_data), .addr_err(b_addr_err)
    );

    // Behavioural cell arrays: written through wordline+bitlines, read through sense amps
    logic [7:0]  cells_a [4] = '{default: '0};
    logic [15:0] cells_b [3] = '{default: '0};
    logic [15:0] noise = 16'h1234;

    always @(posedge clk) begin
        noise <= 16'($urandom);
        for (int i = 0; i < 4; i++) if (a_row_wr[i]) cells_a[i] <= a_bl_wr;
        for (int i = 0; i < 3; i++) if (b_row_wr[i]) cells_b[i] <= b_bl_wr;
    end

    always_comb begin
        a_sa_out = noise[7:0];
        for (int i = 0; i < 4; i++)
            if (a_sense_en && a_row_rd == 4'(1 << i)) a_sa_out = cells_a[i];
    end

    always_comb begin
        b_sa_out = ~noise;
        for (int i = 0; i < 3; i++)
            if (b_sense_en && b_row_rd == 3'(1 << i)) b_sa_out = cells_b[i];
    end

    // Selected instance's outputs, packed for whole-cycle comparison
    logic [60:0] obs;
    always_comb begin
        if (sel) obs = {b_req_ready, 1'b0, b_row_wr, 1'b0, b_row_rd, b_bl_wr, b_blb_wr,
                        b_precharge, b_sense_en, b_rd_valid, b_rd_data, b_addr_err};
        else     obs = {a_req_ready, a_row_wr, a_row_rd, 8'h0, a_bl_wr, 8'h0, a_blb_wr,
                        a_precharge, a_sense_en, a_rd_valid, 8'h0, a_rd_data, a_addr_err};
    end

    function automatic logic [60:0] pack(input logic rdy, input logic [3:0] rw,
                                         input logic [3:0] rr, input logic [15:0] bl,
                                         input logic [15:0] blb, input logic pre,
                                         input logic se, input logic rv,
                                         input logic [15:0] rd, input logic ae);
        return {rdy, rw, rr, bl, blb, pre, se, rv, rd, ae};
    endfunction

    // Reference memory contents and last returned read data per instance
    logic [15:0] ref_mem [2][4] = '{default: '0};
    logic [15:0] exp_rd  [2]    = '{default: '0};

    // Safety properties on both instances every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if ((|a_row_wr && |a_row_rd) || $countones({a_row_wr, a_row_rd}) > 1 ||
                (a_precharge && |{a_row_wr, a_row_rd})) begin
                bad++;
                $display("FAIL excl_a got wr=%b rd=%b pre=%b required exclusive", a_row_wr, a_row_rd, a_precharge);
            end
            total++;
            if ((|b_row_wr && |b_row_rd) || $countones({b_row_wr, b_row_rd}) > 1 ||
                (b_precharge && |{b_row_wr, b_row_rd})) begin
                bad++;
                $display("FAIL excl_b got wr=%b rd=%b pre=%b required exclusive", b_row_wr, b_row_rd, b_precharge);
            end
        end
    end

    // One operation on instance s; checks every cycle of the sequence and the idle cycle after.
    // With chain=1 req_valid stays high through the op so the next call is accepted back-to-back.
    task automatic do_op(input logic s, input logic we, input logic [1:0] addr,
                         input logic [15:0] wd, input logic chain, output longint acc_t);
        int          p, w, rows, occ, n;
        logic [15:0] mask, wdm, rdexp;
        logic        inr, wl, pre, sen, rec;
        logic [3:0]  oh;
        logic [60:0] exp;
        p    = s ? 1 : 2;
        w    = s ? 1 : 3;
        rows = s ? 3 : 4;
        mask = s ? 16'hFFFF : 16'h00FF;
        wdm  = wd & mask;
        inr  = (int'(addr) < rows);
        oh   = inr ? 4'(1 << addr) : 4'h0;
        occ  = we ? w + 2 : p + w + 2;
        sel  = s;
        n    = 0;
        acc_t = 0;
        while (!obs[60] && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!obs[60]) begin
            bad++;
            $display("FAIL ready_timeout got ready=0 required ready=1 within 50 cycles");
            req_valid = 1'b0;
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        acc_t = $time;
        if (we && inr) ref_mem[s][addr] = wdm;
        rdexp = inr ? ref_mem[s][addr] : 16'h0;
        for (int k = 1; k <= occ; k++) begin
            @(negedge clk);
            rec = (k == occ);
            if (we) begin
                pre = 1'b0;
                sen = 1'b0;
                wl  = (k >= 2) && (k <= w + 1);
            end else begin
                pre = (k <= p);
                wl  = (k > p) && (k <= p + w);
                sen = (k == p + w + 1);
            end
            exp = pack(1'b0, (we && wl) ? oh : 4'h0, (!we && (wl || sen)) ? oh : 4'h0,
                       we ? wdm : 16'h0, we ? (~wdm & mask) : 16'h0,
                       pre, sen, !we && rec, (!we && rec) ? rdexp : exp_rd[s], rec && !inr);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL op_cycle s=%0d we=%0d addr=%0d k=%0d got=%h required=%h", s, we, addr, k, obs, exp);
            end
            req_we    = 1'($urandom);
            req_addr  = 2'($urandom);
            req_wdata = 16'($urandom);
            if (rec && !chain) req_valid = 1'b0;
        end
        if (!we) exp_rd[s] = rdexp;
        @(negedge clk);
        exp = pack(1'b1, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, exp_rd[s], 1'b0);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL op_idle s=%0d we=%0d addr=%0d got=%h required=%h", s, we, addr, obs, exp);
        end
    endtask

    task automatic test_reset();
        logic [60:0] idle;
        idle = pack(1'b1, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            total++;
            if (obs !== idle) begin
                bad++;
                $display("FAIL reset_state s=%0d got=%h required=%h", s, obs, idle);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sel = 1'b0;
        #1;
        total++;
        if (obs !== idle) begin
            bad++;
            $display("FAIL after_release got=%h required=%h", obs, idle);
        end
        @(negedge clk);
    endtask

    task automatic test_write();
        longint t;
        do_op(1'b0, 1'b1, 2'd1, 16'h00A5, 1'b0, t);
    endtask

    task automatic test_read();
        longint t;
        do_op(1'b0, 1'b0, 2'd1, 16'h0, 1'b0, t);
        total++;
        if (a_rd_data !== 8'hA5) begin
            bad++;
            $display("FAIL read_row1 got=%h required=a5", a_rd_data);
        end
    endtask

    task automatic test_abort();
        logic [60:0] exp;
        sel = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 2'd2;
        req_wdata = 16'h003C;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        exp = pack(1'b0, 4'b0100, 4'h0, 16'h003C, 16'h00C3, 1'b0, 1'b0, 1'b0, exp_rd[0], 1'b0);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL abort_in_wl got=%h required=%h", obs, exp);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_rd[0] = 16'h0;
        exp_rd[1] = 16'h0;
        exp = pack(1'b1, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL abort_async got=%h required=%h", obs, exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL abort_idle got=%h required=%h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        longint t0, t1, t2, t3;
        do_op(1'b0, 1'b1, 2'd0, 16'h00FF, 1'b1, t0);
        do_op(1'b0, 1'b0, 2'd0, 16'h0,    1'b1, t1);
        do_op(1'b0, 1'b1, 2'd0, 16'h0000, 1'b1, t2);
        do_op(1'b0, 1'b0, 2'd0, 16'h0,    1'b0, t3);
        total++;
        if ((t1 - t0) / 10 != 6 || (t2 - t1) / 10 != 8 || (t3 - t2) / 10 != 6) begin
            bad++;
            $display("FAIL b2b_gap got=%0d,%0d,%0d required=6,8,6", (t1 - t0) / 10, (t2 - t1) / 10, (t3 - t2) / 10);
        end
        total++;
        if (a_rd_data !== 8'h00) begin
            bad++;
            $display("FAIL b2b_last_read got=%h required=00", a_rd_data);
        end
    endtask

    task automatic test_out_of_range();
        longint t;
        do_op(1'b1, 1'b1, 2'd1, 16'hBEEF, 1'b0, t);
        do_op(1'b1, 1'b0, 2'd1, 16'h0,    1'b0, t);
        do_op(1'b1, 1'b0, 2'd3, 16'h0,    1'b0, t);
        total++;
        if (b_rd_data !== 16'h0) begin
            bad++;
            $display("FAIL oor_read got=%h required=0000", b_rd_data);
        end
        do_op(1'b1, 1'b1, 2'd3, 16'h1357, 1'b0, t);
    endtask

    task automatic test_random();
        longint t;
        logic   ch;
        for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < (s ? 3 : 4); r++)
                do_op(1'(s), 1'b1, 2'(r), 16'($urandom), 1'b0, t);
            for (int i = 0; i < 40; i++) begin
                ch = (i < 39) ? 1'($urandom) : 1'b0;
                do_op(1'(s), 1'($urandom), 2'($urandom_range(0, 3)), 16'($urandom), ch, t);
            end
        end
    endtask

    initial begin
        sel       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 2'd0;
        req_wdata = 16'h0;
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_back_to_back();
        test_out_of_range();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_array_ctrl.md
# sram_array_ctrl

Cycle-level controller for a ROWS x COLS split-port SRAM cell array (separate write and read wordlines and bitline pairs per column). It converts a single-request valid/ready interface into timed precharge, wordline, bitline-drive and sense-enable sequences with parametrised phase lengths. It sits between the digital memory client and the mixed-signal `cell_array`/sense-amp layer; real-valued level conversion of its outputs happens in the analog wrapper.

## Interface
Parameters:
- ROWS, 4, number of wordlines (rows); need not be a power of two
- COLS, 8, data width (columns)
- ADDR_W, $clog2(ROWS) (minimum 1), row address width
- PRE_CYC, 2, read precharge cycles (>=1)
- WL_CYC, 3, wordline-high cycles for both read and write (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller idle, can accept
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  row address
- req_wdata  in  COLS  write data
- row_wr  out  ROWS  one-hot write wordlines
- row_rd  out  ROWS  one-hot read wordlines
- bl_wr  out  COLS  write bitline drive (true)
- blb_wr  out  COLS  write bitline drive (complement)
- precharge  out  1  read bitline precharge enable
- sense_en  out  1  sense-amp enable
- sa_out  in  COLS  sense-amp outputs, valid while sense_en=1
- rd_valid  out  1  single-cycle read-data strobe
- rd_data  out  COLS  read data, held until next read completes
- addr_err  out  1  with rd_valid or write completion: address >= ROWS

## Operation
- Reset value of every output 0, except req_ready=1. Reset assertion mid-operation forces all wordlines, bitline drives, precharge, sense_en low immediately (asynchronous), state to IDLE, rd_data to 0; no response for the aborted request.
- Acceptance: req_valid && req_ready at a rising edge. req_ready=1 only in IDLE. Request fields are registered at acceptance; inputs are ignored afterwards.
- States: IDLE, SETUP, PRE, WL, SENSE, REC.
- Write: IDLE -> SETUP (1 cycle) -> WL (WL_CYC cycles) -> REC (1 cycle) -> IDLE.
  - bl_wr = wdata, blb_wr = ~wdata during SETUP, WL, REC; 0/0 otherwise.
  - row_wr[addr]=1 only in WL.
- Read: IDLE -> PRE (PRE_CYC) -> WL (WL_CYC) -> SENSE (1) -> REC (1) -> IDLE.
  - precharge=1 only in PRE; row_rd[addr]=1 in WL and SENSE; sense_en=1 only in SENSE.
  - rd_data <= sa_out at the SENSE->REC edge; rd_valid=1 for exactly the REC cycle.
- Never row_wr and row_rd both nonzero; never more than one wordline high; wordlines never high in the same cycle as precharge.
- Out-of-range address (addr >= ROWS): full timing sequence runs, no wordline asserted; a read returns rd_data=0; addr_err=1 in the REC cycle (reads and writes), else 0.
- Phase counter wide enough for max(PRE_CYC, WL_CYC); reloaded on every state entry.

## Timing
- Acceptance edge E0. Write: SETUP E0-E1, WL E1-E(1+WL_CYC), REC, req_ready=1 from E(2+WL_CYC). Occupancy WL_CYC+2 cycles.
- Read: PRE E0-E(PRE_CYC), WL to E(PRE_CYC+WL_CYC), SENSE 1 cycle, rd_valid in cycle E(P+W+1)-E(P+W+2), req_ready=1 from E(PRE_CYC+WL_CYC+2). Defaults: read latency to rd_valid = 6 cycles after acceptance edge, write occupancy 5.
- Back-to-back: request held valid in REC is accepted at the REC->IDLE+1 edge (one IDLE cycle minimum between operations, guaranteed bitline recovery).
- All outputs registered (decoded from registered state/address); no combinational path from req_* to outputs other than none (req_ready from state only).

## Test plan
- Reset: rst_n=0 at power-up -> req_ready=1, all other outputs 0; assert rst_n=0 during WL of a write to row 2 -> row_wr=0 within the same cycle, state IDLE after release.
- Write 0xA5 to row 1 (defaults) -> SETUP 1 cycle with bl_wr=0xA5/blb_wr=0x5A, row_wr=4'b0010 exactly 3 cycles, req_ready back 5 cycles after acceptance.
- Read row 1 with sa_out model returning 0xA5 -> precharge 2 cycles, row_rd=4'b0010 for 4 cycles, sense_en 1 cycle, rd_valid one cycle with rd_data=0xA5 at 6 cycles after acceptance.
- Write 1 then read 0 sequence on row 0 (mirrors cell write/read pattern), req_valid held continuously -> one IDLE cycle between each op, rd_data=0xFF then 0x00.
- ROWS=3, read addr 3 -> no wordline ever high, rd_valid with rd_data=0, addr_err=1.
- Parameter sweep PRE_CYC=1, WL_CYC=1, COLS=16 -> read latency 3 cycles, write occupancy 3, mutual-exclusion assertions hold throughout random traffic.
